// File: rtl/alu_pkg.sv
// Shared ALU control codes, MIPS opcode/funct values and the issue bundle
// type used by the ID/EX issue stage.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [1:0] {IN1_RS, IN1_RT, IN1_LUI, IN1_ZERO} in1_sel_e;
    typedef enum logic [2:0] {IN2_RT, IN2_IMM, IN2_SHAMT, IN2_SIXTEEN, IN2_ZERO} in2_sel_e;
    typedef enum logic {EXT_SIGN, EXT_ZERO} ext_e;
    typedef enum logic [1:0] {DEST_RD, DEST_RT, DEST_ZERO} dest_sel_e;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  dest;
        logic        reg_write;
        logic        illegal;
    } issue_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder: ALU code plus the operand, extension
// and destination selects consumed by the issue stage muxes.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output in1_sel_e   in1_sel,
    output in2_sel_e   in2_sel,
    output ext_e       ext_sel,
    output dest_sel_e  dest_sel,
    output logic       reg_write,
    output logic       illegal
);

    // Defaults describe the illegal case so unknown encodings fall through cleanly
    always_comb begin
        alu_ctrl  = ALU_ADD;
        in1_sel   = IN1_ZERO;
        in2_sel   = IN2_ZERO;
        ext_sel   = EXT_SIGN;
        dest_sel  = DEST_ZERO;
        reg_write = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                in1_sel   = IN1_RS;
                in2_sel   = IN2_RT;
                dest_sel  = DEST_RD;
                reg_write = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: alu_ctrl = ALU_ADD;
                    F_SUB, F_SUBU: alu_ctrl = ALU_SUB;
                    F_AND:         alu_ctrl = ALU_AND;
                    F_OR:          alu_ctrl = ALU_OR;
                    F_SLT:         alu_ctrl = ALU_SLT;
                    F_SLTU:        alu_ctrl = ALU_SLTU;
                    F_SLL, F_SRL: begin
                        alu_ctrl = (funct == F_SLL) ? ALU_SLL : ALU_SRL;
                        in1_sel  = IN1_RT;
                        in2_sel  = IN2_SHAMT;
                    end
                    default: begin
                        in1_sel   = IN1_ZERO;
                        in2_sel   = IN2_ZERO;
                        dest_sel  = DEST_ZERO;
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: begin
                in1_sel   = IN1_RS;
                in2_sel   = IN2_IMM;
                dest_sel  = DEST_RT;
                reg_write = 1'b1;
                case (opcode)
                    OP_SLTI:  alu_ctrl = ALU_SLT;
                    OP_SLTIU: alu_ctrl = ALU_SLTU;
                    OP_ANDI:  alu_ctrl = ALU_AND;
                    OP_ORI:   alu_ctrl = ALU_OR;
                    default:  alu_ctrl = ALU_ADD;
                endcase
                if (opcode == OP_ANDI || opcode == OP_ORI)
                    ext_sel = EXT_ZERO;
            end
            OP_LUI: begin
                alu_ctrl  = ALU_SLL;
                in1_sel   = IN1_LUI;
                in2_sel   = IN2_SIXTEEN;
                dest_sel  = DEST_RT;
                reg_write = 1'b1;
            end
            OP_LW, OP_LH, OP_LHU: begin
                in1_sel   = IN1_RS;
                in2_sel   = IN2_IMM;
                dest_sel  = DEST_RT;
                reg_write = 1'b1;
            end
            OP_SW, OP_SH: begin
                in1_sel = IN1_RS;
                in2_sel = IN2_IMM;
            end
            OP_BEQ, OP_BNE: begin
                alu_ctrl = ALU_SUB;
                in1_sel  = IN1_RS;
                in2_sel  = IN2_RT;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes, selects ALU operands and registers them for one
// cycle with stall/flush. Define ALU_ISSUE_FWD_EN to add operand forwarding ports.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic [4:0]           shamt,
    input  logic [15:0]          imm16,
    input  logic [REG_IDX_W-1:0] rt_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic [DATA_W-1:0]    rs_data,
    input  logic [DATA_W-1:0]    rt_data,
`ifdef ALU_ISSUE_FWD_EN
    input  logic                 fwd_rs_en,
    input  logic                 fwd_rt_en,
    input  logic [DATA_W-1:0]    fwd_data,
`endif
    input  logic                 stall,
    input  logic                 flush,
    output logic                 valid_out,
    output logic [2:0]           alu_ctrl,
    output logic [DATA_W-1:0]    alu_in1,
    output logic [DATA_W-1:0]    alu_in2,
    output logic [REG_IDX_W-1:0] dest_idx,
    output logic                 reg_write,
    output logic                 illegal
);

    logic [2:0]        dec_ctrl;
    in1_sel_e          in1_sel;
    in2_sel_e          in2_sel;
    ext_e              ext_sel;
    dest_sel_e         dest_sel;
    logic              dec_reg_write;
    logic              dec_illegal;
    logic [DATA_W-1:0] rs_eff;
    logic [DATA_W-1:0] rt_eff;
    logic [DATA_W-1:0] imm_ext;
    issue_t            next_issue;
    issue_t            issue_q;
    logic              valid_q;

    alu_ctrl_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .alu_ctrl  (dec_ctrl),
        .in1_sel   (in1_sel),
        .in2_sel   (in2_sel),
        .ext_sel   (ext_sel),
        .dest_sel  (dest_sel),
        .reg_write (dec_reg_write),
        .illegal   (dec_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    assign rs_eff = fwd_rs_en ? fwd_data : rs_data;
    assign rt_eff = fwd_rt_en ? fwd_data : rt_data;
`else
    assign rs_eff = rs_data;
    assign rt_eff = rt_data;
`endif

    // A bubble (valid_in low) must never write back or raise illegal downstream
    always_comb begin
        imm_ext = (ext_sel == EXT_ZERO) ? {{(DATA_W-16){1'b0}}, imm16}
                                        : {{(DATA_W-16){imm16[15]}}, imm16};
        next_issue = '0;
        next_issue.ctrl = dec_ctrl;
        case (in1_sel)
            IN1_RS:  next_issue.in1 = rs_eff;
            IN1_RT:  next_issue.in1 = rt_eff;
            IN1_LUI: next_issue.in1 = {{(DATA_W-16){1'b0}}, imm16};
            default: next_issue.in1 = '0;
        endcase
        case (in2_sel)
            IN2_RT:      next_issue.in2 = rt_eff;
            IN2_IMM:     next_issue.in2 = imm_ext;
            IN2_SHAMT:   next_issue.in2 = {{(DATA_W-5){1'b0}}, shamt};
            IN2_SIXTEEN: next_issue.in2 = 32'd16;
            default:     next_issue.in2 = '0;
        endcase
        case (dest_sel)
            DEST_RD: next_issue.dest = rd_idx;
            DEST_RT: next_issue.dest = rt_idx;
            default: next_issue.dest = '0;
        endcase
        next_issue.reg_write = dec_reg_write & valid_in;
        next_issue.illegal   = dec_illegal & valid_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            issue_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            issue_q <= '0;
        end else if (!stall) begin
            valid_q <= valid_in;
            issue_q <= next_issue;
        end
    end

    assign valid_out = valid_q;
    assign alu_ctrl  = issue_q.ctrl;
    assign alu_in1   = issue_q.in1;
    assign alu_in2   = issue_q.in2;
    assign dest_idx  = issue_q.dest;
    assign reg_write = issue_q.reg_write;
    assign illegal   = issue_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary block that produces everything the pipeline ALU consumes: the 3-bit ALU control code and the two selected 32-bit operands.
- Decodes MIPS opcode/funct and picks register, immediate or shamt operands.
- Registers the result for one cycle, with stall and flush support.
- Its outputs drive the ALU In1/In2/ALUcontrol directly, together with write-back destination info.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  instruction fields below are valid this cycle
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- shamt  in  5  instr[10:6]
- imm16  in  16  instr[15:0]
- rt_idx  in  5  instr[20:16]
- rd_idx  in  5  instr[15:11]
- rs_data  in  32  register-file rs value
- rt_data  in  32  register-file rt value
- stall  in  1  hold output register
- flush  in  1  kill the instruction being registered
- valid_out  out  1  outputs hold a live op
- alu_ctrl  out  3  ALU control code
- alu_in1  out  32  ALU operand 1
- alu_in2  out  32  ALU operand 2
- dest_idx  out  5  write-back register index
- reg_write  out  1  op writes a register
- illegal  out  1  unsupported opcode/funct

Behaviour:
- ALU codes: AND=000, OR=001, ADD=010, SLTU=011, SRL=100, SLL=101, SUB=110, SLT=111.
- R-type (opcode 0x00), in1=rs_data, in2=rt_data, dest=rd_idx, reg_write=1:
  - funct 0x20/0x21 -> ADD
  - 0x22/0x23 -> SUB
  - 0x24 -> AND
  - 0x25 -> OR
  - 0x2A -> SLT
  - 0x2B -> SLTU
- Shifts: funct 0x00 -> SLL, 0x02 -> SRL; in1=rt_data, in2={27'b0,shamt}.
- Sign-extended immediate, dest=rt_idx, reg_write=1:
  - 0x08/0x09 -> ADD
  - 0x0A -> SLT
  - 0x0B -> SLTU
- Zero-extended immediate, dest=rt_idx, reg_write=1: 0x0C -> AND, 0x0D -> OR.
- lui 0x0F: SLL with in1={16'b0,imm16}, in2=16, dest=rt_idx, reg_write=1.
- Loads 0x23/0x21/0x25: ADD with rs_data + sign-extended imm, dest=rt_idx, reg_write=1.
- Stores 0x2B/0x29: ADD with rs_data + sign-extended imm, reg_write=0, dest=0.
- Branches beq 0x04 / bne 0x05: SUB with in1=rs_data, in2=rt_data, reg_write=0, dest=0.
- Anything else: illegal=1, alu_ctrl=ADD, in1=in2=0, reg_write=0, dest=0.
- Latency: 1 cycle; fields sampled at edge N appear on outputs after edge N.
- Register update priority, highest first:
  1. rst_n=0 -> all outputs 0 (valid_out=0, alu_ctrl=000, operands 0, dest 0, reg_write 0, illegal 0).
  2. flush=1 -> valid_out=0, reg_write=0, illegal=0; other fields don't-care but driven 0.
  3. stall=1 -> every output holds.
  4. Otherwise load the decoded values; valid_out=valid_in.
- flush and stall together: flush wins.
- Reset asserted mid-stall clears state; the stalled op is lost.
- valid_in=0 (not stalled): valid_out=0, reg_write=0, illegal=0.
- Outputs change only at clock edges; no combinational path from inputs to outputs.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Defined: adds ports fwd_rs_en in 1, fwd_rt_en in 1, fwd_data in 32.
  - When an enable is set, fwd_data replaces rs_data / rt_data before operand selection.
  - This includes the shift in1 (rt) and the branch operands.
- Undefined: ports absent; register-file data used directly.

Decomposition:
- Package alu_pkg:
  - ALU code constants (ALU_AND..ALU_SLT).
  - Opcode and funct localparams.
  - Typedef for the issue bundle (ctrl, in1, in2, dest, reg_write, illegal).
- One natural combinational sub-module, alu_ctrl_decode (opcode, funct -> alu_ctrl, operand-select, ext type, dest select, reg_write, illegal).
- Top level holds the operand muxes and the output register.

Test Plan:
- Reset: rst_n=0 for 2 cycles with valid_in=1, opcode 0x08 -> all outputs 0; first op appears on the cycle after release.
- R-type sub: funct 0x22, rs=7, rt=3, rd=9 -> next cycle alu_ctrl=110, in1=7, in2=3, dest=9, reg_write=1, valid_out=1.
- Immediates:
  - addi with imm16=0xFFFF, rs=5 -> in2=0xFFFFFFFF, ctrl=010.
  - ori with imm16=0xFFFF -> in2=0x0000FFFF, ctrl=001.
  - lui with imm16=0x1234 -> in1=0x00001234, in2=16, ctrl=101.
- Shift: sll, shamt=4, rt=0x1 -> in1=0x1, in2=4, ctrl=101; sw -> reg_write=0, dest=0.
- Stall/flush:
  - Hold stall 3 cycles while inputs change -> outputs frozen.
  - Assert flush and stall together -> valid_out=0 next cycle.
- Illegal opcode 0x3F -> valid_out=1, illegal=1, reg_write=0, operands 0.
- With ALU_ISSUE_FWD_EN: fwd_rs_en=1, fwd_data=0xAA -> in1=0xAA.
